// File: rtl/fft_frame_feeder.sv
// Bridges the audio sample FIFO read port to the FFT streaming sink: collapses each
// channel-interleaved sample group into one real sample and frames it with sop/eop.
module fft_frame_feeder #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 2,
  parameter int FRAME_LEN  = 1024
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  mode,
  input  logic [1:0]            ch_sel,
  input  logic                  sink_ready,
  output logic                  sink_valid,
  output logic                  sink_sop,
  output logic                  sink_eop,
  output logic [DATA_WIDTH-1:0] sink_real,
  output logic [DATA_WIDTH-1:0] sink_imag,
  output logic [15:0]           frame_cnt
);

  localparam int CH_W  = (CHANNELS == 4) ? 2 : ((CHANNELS == 2) ? 1 : 0);
  localparam int CNT_W = (CH_W == 0) ? 1 : CH_W;
  localparam int ACC_W = DATA_WIDTH + CH_W;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CH  = CNT_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]        r_ch_cnt;
  logic [IDX_W-1:0]        r_samp_idx;
  logic                    r_rd_pending;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_mode;
  logic [1:0]              r_sel;
  logic                    r_sink_valid;
  logic                    r_sink_sop;
  logic                    r_sink_eop;
  logic [DATA_WIDTH-1:0]   r_sink_real;
  logic [15:0]             r_frame_cnt;

  logic                    w_rd_en;
  logic                    w_xfer;
  logic [IDX_W-1:0]        w_idx_next;
  logic [1:0]              w_sel_in;
  logic                    w_latch;
  logic                    w_mode_eff;
  logic [1:0]              w_sel_eff;
  logic                    w_sel_hit;
  logic                    w_last_ch;
  logic                    w_emit;
  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_sum;
  logic [DATA_WIDTH-1:0]   w_reduced;

  // Read issue, handshake and reduction datapath; a read is only issued when the output slot is free
  always_comb begin
    w_rd_en    = RESET & ~fifo_empty & ~r_rd_pending & (~r_sink_valid | sink_ready);
    w_xfer     = r_sink_valid & sink_ready;
    w_idx_next = r_samp_idx;
    if (w_xfer) begin
      w_idx_next = r_samp_idx + IDX_W'(1);
    end else begin
      w_idx_next = r_samp_idx;
    end
    w_sel_in = (32'(ch_sel) < CHANNELS) ? ch_sel : 2'd0;
    w_latch  = r_rd_pending & (r_ch_cnt == {CNT_W{1'b0}}) & (w_idx_next == {IDX_W{1'b0}});
    if (w_latch) begin
      w_mode_eff = mode;
      w_sel_eff  = w_sel_in;
    end else begin
      w_mode_eff = r_mode;
      w_sel_eff  = r_sel;
    end
    w_sel_hit = (2'(r_ch_cnt) == w_sel_eff);
    w_last_ch = (r_ch_cnt == LAST_CH);
    w_emit    = r_rd_pending & w_last_ch;
    w_sext    = ACC_W'($signed(fifo_data));
    w_sum     = r_acc + w_sext;
    // Dropping the low CH_W bits of the sum is an arithmetic shift toward -inf
    if (w_mode_eff) begin
      w_reduced = w_sum[ACC_W-1:CH_W];
    end else if (w_sel_hit) begin
      w_reduced = fifo_data;
    end else begin
      w_reduced = r_hold;
    end
  end

  // Capture, framing and output registers
  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      r_ch_cnt     <= {CNT_W{1'b0}};
      r_samp_idx   <= {IDX_W{1'b0}};
      r_rd_pending <= 1'b0;
      r_acc        <= {ACC_W{1'b0}};
      r_hold       <= {DATA_WIDTH{1'b0}};
      r_mode       <= 1'b0;
      r_sel        <= 2'd0;
      r_sink_valid <= 1'b0;
      r_sink_sop   <= 1'b0;
      r_sink_eop   <= 1'b0;
      r_sink_real  <= {DATA_WIDTH{1'b0}};
      r_frame_cnt  <= 16'd0;
    end else begin
      r_rd_pending <= w_rd_en;
      if (w_xfer) begin
        r_samp_idx <= w_idx_next;
        if (r_sink_eop) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
      if (w_emit) begin
        r_sink_valid <= 1'b1;
        r_sink_real  <= w_reduced;
        r_sink_sop   <= (w_idx_next == {IDX_W{1'b0}});
        r_sink_eop   <= (w_idx_next == LAST_IDX);
      end else if (w_xfer) begin
        r_sink_valid <= 1'b0;
      end
      if (r_rd_pending) begin
        r_ch_cnt <= w_last_ch ? {CNT_W{1'b0}} : r_ch_cnt + CNT_W'(1);
        if (w_latch) begin
          r_mode <= mode;
          r_sel  <= w_sel_in;
        end
        if (w_sel_hit) begin
          r_hold <= fifo_data;
        end
        r_acc <= w_emit ? {ACC_W{1'b0}} : w_sum;
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign sink_valid = r_sink_valid;
  assign sink_sop   = r_sink_sop;
  assign sink_eop   = r_sink_eop;
  assign sink_real  = r_sink_real;
  assign sink_imag  = {DATA_WIDTH{1'b0}};
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: a 2-channel instance for framing, averaging,
// backpressure, drain and reset, plus a 4-channel instance for the mid-frame mode change.
module tb_fft_frame_feeder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic        a_empty, a_rd, a_mode, a_ready, a_valid, a_sop, a_eop;
  logic [23:0] a_data, a_real, a_imag;
  logic [1:0]  a_sel;
  logic [15:0] a_fcnt;
  logic        b_empty, b_rd, b_mode, b_ready, b_valid, b_sop, b_eop;
  logic [23:0] b_data, b_real, b_imag;
  logic [1:0]  b_sel;
  logic [15:0] b_fcnt;

  logic [23:0] mem_a [0:127];
  logic [23:0] mem_b [0:127];
  int pa, qa, pb, qb;
  logic [23:0] oa_v [0:63];
  logic        oa_s [0:63];
  logic        oa_e [0:63];
  logic [23:0] ob_v [0:63];
  logic        ob_s [0:63];
  logic        ob_e [0:63];
  int oa_n, ob_n;
  logic a_prev_rd;
  int   a_consec;

  fft_frame_feeder #(.DATA_WIDTH(24), .CHANNELS(2), .FRAME_LEN(8)) u_dut_a (
    .MCLK(clk), .RESET(rst_n), .fifo_empty(a_empty), .fifo_data(a_data), .fifo_rd_en(a_rd),
    .mode(a_mode), .ch_sel(a_sel), .sink_ready(a_ready), .sink_valid(a_valid),
    .sink_sop(a_sop), .sink_eop(a_eop), .sink_real(a_real), .sink_imag(a_imag),
    .frame_cnt(a_fcnt)
  );

  fft_frame_feeder #(.DATA_WIDTH(24), .CHANNELS(4), .FRAME_LEN(8)) u_dut_b (
    .MCLK(clk), .RESET(rst_n), .fifo_empty(b_empty), .fifo_data(b_data), .fifo_rd_en(b_rd),
    .mode(b_mode), .ch_sel(b_sel), .sink_ready(b_ready), .sink_valid(b_valid),
    .sink_sop(b_sop), .sink_eop(b_eop), .sink_real(b_real), .sink_imag(b_imag),
    .frame_cnt(b_fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign a_empty = (pa == qa);
  assign b_empty = (pb == qb);

  // FIFO models (data one cycle after rd_en) and sink-side transfer monitors
  always @(posedge clk) begin
    if (a_rd && qa != pa) begin
      a_data <= mem_a[qa];
      qa <= qa + 1;
    end
    if (b_rd && qb != pb) begin
      b_data <= mem_b[qb];
      qb <= qb + 1;
    end
    if (a_valid && a_ready) begin
      oa_v[oa_n] <= a_real;
      oa_s[oa_n] <= a_sop;
      oa_e[oa_n] <= a_eop;
      oa_n <= oa_n + 1;
    end
    if (b_valid && b_ready) begin
      ob_v[ob_n] <= b_real;
      ob_s[ob_n] <= b_sop;
      ob_e[ob_n] <= b_eop;
      ob_n <= ob_n + 1;
    end
    a_prev_rd <= a_rd;
    if (a_prev_rd && a_rd) a_consec <= a_consec + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [23:0] d0, input logic [23:0] d1);
    mem_a[pa] = d0;
    mem_a[pa + 1] = d1;
    pa = pa + 2;
  endtask

  task automatic push_b(input logic [23:0] d0, input logic [23:0] d1,
                        input logic [23:0] d2, input logic [23:0] d3);
    mem_b[pb] = d0;
    mem_b[pb + 1] = d1;
    mem_b[pb + 2] = d2;
    mem_b[pb + 3] = d3;
    pb = pb + 4;
  endtask

  task automatic wait_a(input int n);
    int k;
    k = 0;
    while (oa_n < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_a", 32'(oa_n >= n), 32'd1);
  endtask

  task automatic wait_b(input int n);
    int k;
    k = 0;
    while (ob_n < n && k < 800) begin
      @(negedge clk);
      k++;
    end
    chk("wait_b", 32'(ob_n >= n), 32'd1);
  endtask

  task automatic chk_a(input int i, input logic [23:0] v, input logic s, input logic e);
    chk($sformatf("a_real[%0d]", i), 32'(oa_v[i]), 32'(v));
    chk($sformatf("a_sop[%0d]", i), 32'(oa_s[i]), 32'(s));
    chk($sformatf("a_eop[%0d]", i), 32'(oa_e[i]), 32'(e));
  endtask

  task automatic chk_b(input int i, input logic [23:0] v, input logic s, input logic e);
    chk($sformatf("b_real[%0d]", i), 32'(ob_v[i]), 32'(v));
    chk($sformatf("b_sop[%0d]", i), 32'(ob_s[i]), 32'(s));
    chk($sformatf("b_eop[%0d]", i), 32'(ob_e[i]), 32'(e));
  endtask

  initial begin
    logic seen;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_mode = 1'b0; a_sel = 2'd1; a_ready = 1'b1;
    b_mode = 1'b1; b_sel = 2'd0; b_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_sop", 32'(a_sop), 32'd0);
    chk("rst_eop", 32'(a_eop), 32'd0);
    chk("rst_real", 32'(a_real), 32'd0);
    chk("rst_imag", 32'(a_imag), 32'd0);
    chk("rst_fcnt", 32'(a_fcnt), 32'd0);
    chk("rst_rd", 32'(a_rd), 32'd0);
    rst_n = 1'b1;

    // Channel select: 16 L/R pairs, right channel chosen
    for (int i = 0; i < 16; i++) push_a(24'(i), 24'(100 + i));
    wait_a(16);
    for (int i = 0; i < 16; i++) chk_a(i, 24'(100 + i), (i % 8) == 0, (i % 8) == 7);
    chk("fcnt_2", 32'(a_fcnt), 32'd2);

    // Channel average with floor rounding and full-scale extremes
    a_mode = 1'b1;
    push_a(24'd3, 24'd4);
    push_a(24'hFFFFFD, 24'hFFFFFC);
    push_a(24'h7FFFFF, 24'h7FFFFF);
    push_a(24'h800000, 24'h800000);
    wait_a(20);
    chk_a(16, 24'd3, 1'b1, 1'b0);
    chk_a(17, 24'hFFFFFC, 1'b0, 1'b0);
    chk_a(18, 24'h7FFFFF, 1'b0, 1'b0);
    chk_a(19, 24'h800000, 1'b0, 1'b0);
    chk("imag_zero", 32'(a_imag), 32'd0);

    // Backpressure for 20 cycles with more data waiting in the FIFO
    a_ready = 1'b0;
    push_a(24'd10, 24'd20);
    push_a(24'd30, 24'd50);
    for (int k = 0; k < 50 && !a_valid; k++) @(negedge clk);
    chk("bp_valid_up", 32'(a_valid), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_real", 32'(a_real), 32'd15);
      chk("bp_sop", 32'(a_sop), 32'd0);
      chk("bp_eop", 32'(a_eop), 32'd0);
      chk("bp_rd", 32'(a_rd), 32'd0);
    end
    a_ready = 1'b1;
    wait_a(22);
    chk_a(20, 24'd15, 1'b0, 1'b0);
    chk_a(21, 24'd40, 1'b0, 1'b0);

    // FIFO drains at samp_idx 6; 50 idle cycles, then the frame continues
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_valid) seen = 1'b1;
    end
    chk("drain_no_valid", 32'(seen), 32'd0);
    chk("drain_count", 32'(oa_n), 32'd22);
    push_a(24'd2, 24'd6);
    push_a(24'd9, 24'd9);
    wait_a(24);
    chk_a(22, 24'd4, 1'b0, 1'b0);
    chk_a(23, 24'd9, 1'b0, 1'b1);
    chk("fcnt_3", 32'(a_fcnt), 32'd3);

    // One-edge reset at samp_idx 4, then a fresh frame
    push_a(24'd1, 24'd1);
    push_a(24'd2, 24'd2);
    push_a(24'd3, 24'd3);
    push_a(24'd4, 24'd4);
    wait_a(28);
    chk_a(27, 24'd4, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_real", 32'(a_real), 32'd0);
    chk("rst2_valid", 32'(a_valid), 32'd0);
    chk("rst2_fcnt", 32'(a_fcnt), 32'd0);
    push_a(24'd6, 24'd8);
    wait_a(29);
    chk_a(28, 24'd7, 1'b1, 1'b0);
    chk("rst2_fcnt_after", 32'(a_fcnt), 32'd0);
    chk("rd_never_back_to_back", 32'(a_consec), 32'd0);

    // 4 channels: average, switch to channel 2 at samp_idx 3 (takes effect next frame)
    push_b(24'd1, 24'd2, 24'd3, 24'd5);
    push_b(24'd4, 24'd4, 24'd4, 24'd4);
    push_b(24'd8, 24'd0, 24'd0, 24'd0);
    wait_b(3);
    b_mode = 1'b0;
    b_sel = 2'd2;
    for (int i = 0; i < 6; i++) push_b(24'd10, 24'd20, 24'd30, 24'd40);
    wait_b(9);
    chk_b(0, 24'd2, 1'b1, 1'b0);
    chk_b(1, 24'd4, 1'b0, 1'b0);
    chk_b(2, 24'd2, 1'b0, 1'b0);
    for (int i = 3; i < 8; i++) chk_b(i, 24'd25, 1'b0, i == 7);
    chk_b(8, 24'd30, 1'b1, 1'b0);
    chk("b_fcnt", 32'(b_fcnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Single-clock bridge between the read side of the audio sample FIFO and the streaming sink of the FFT core. It pops channel-interleaved ADC words from the FIFO, reduces each multi-channel sample group to one real value (selected channel or channel average), and emits FFT input frames of FRAME_LEN samples. Framing uses sop/eop, with full backpressure from sink_ready. It replaces the direct FIFO-to-FFT wiring and generalises it in word width, channel count, frame length and reduction mode.

## Interface
- DATA_WIDTH, 24: width of FIFO words and of sink_real/sink_imag.
- CHANNELS, 2: interleaved channels per sample group. Legal values are 1, 2 and 4.
- FRAME_LEN, 1024: output samples per FFT frame. Power of two, 8..65536.
- MCLK  in  1: system clock. All logic is on the rising edge.
- RESET  in  1: reset. It is synchronous and active-low.
- fifo_empty  in  1: FIFO read-side empty flag.
- fifo_data  in  DATA_WIDTH: FIFO output word, two's complement. Valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1: FIFO read strobe.
- mode  in  1: 0 = select channel ch_sel; 1 = average of all channels.
- ch_sel  in  2: channel index for mode 0. Values ≥ CHANNELS are treated as 0.
- sink_ready  in  1: FFT ready to accept a sample.
- sink_valid  out  1: sample on sink_real is valid.
- sink_sop  out  1: first sample of a frame.
- sink_eop  out  1: last sample of a frame.
- sink_real  out  DATA_WIDTH: reduced sample.
- sink_imag  out  DATA_WIDTH: always 0.
- frame_cnt  out  16: count of completed frames, wrapping.

## Operation
- Reset (RESET=0 at an MCLK edge) sets the following. The reset is effective mid-frame; the partial frame is discarded and the first sample after reset carries sop.
  - Outputs: fifo_rd_en=0, sink_valid=0, sink_sop=0, sink_eop=0, sink_real=0, sink_imag=0, frame_cnt=0.
  - Internal state: ch_cnt=0, samp_idx=0, rd_pending=0, accumulator=0.
- Read issue: fifo_rd_en = !fifo_empty && !rd_pending && (!sink_valid || sink_ready), registered combinationally from current state. rd_pending is set on the cycle after fifo_rd_en.
  - This guarantees the output register is free whenever a read lands.
  - At most one read is in flight. Peak rate is one FIFO word per 2 MCLK cycles.
- Capture (rd_pending=1): fifo_data is taken as channel ch_cnt. ch_cnt then increments modulo CHANNELS.
- Mode latch: mode and ch_sel are latched when the channel-0 word of the group with samp_idx=0 is captured. They are constant for the whole frame. Changes mid-frame take effect at the next frame.
- Mode 0: the word with ch_cnt == latched ch_sel is held. Other channels are discarded.
- Mode 1: the accumulator is (DATA_WIDTH+log2 CHANNELS) bits wide and sums the sign-extended words. The result is an arithmetic shift right by log2 CHANNELS, i.e. rounding toward −∞. It cannot overflow. With CHANNELS=1, the result is the input word.
- Emit: on capture of channel CHANNELS-1, the reduced value loads sink_real and sink_valid is set.
  - sink_sop = (samp_idx==0).
  - sink_eop = (samp_idx==FRAME_LEN-1).
  - In mode 1 the accumulator clears on the same cycle.
- Handshake: a transfer occurs when sink_valid && sink_ready. On transfer:
  - samp_idx increments, wrapping to 0 after FRAME_LEN-1.
  - If eop was set, frame_cnt increments, wrapping at 0xFFFF→0.
  - If no new sample loads that cycle, sink_valid clears.
  - While sink_valid=1 and sink_ready=0, sink_real, sink_sop and sink_eop are held stable.
- FIFO empty: no read is issued and state is held. Frames may contain arbitrary gaps between samples, including mid-frame.

## Timing
- Latency: fifo_rd_en for the last channel word (cycle t) → data captured at t+1 → sink_valid=1 at t+2.
- Steady state with fifo_empty=0 and sink_ready=1: one output per 2·CHANNELS cycles.
- sink_ready low while sink_valid=1: fifo_rd_en=0 from that cycle. Reads resume the cycle sink_ready rises, since issue and transfer may share a cycle.
- Simultaneous transfer and load on the same edge: sink_valid stays 1 and the new value replaces the old.
- RESET low for one edge while rd_pending=1: the in-flight word is dropped. The FIFO pointer has still advanced, so channel alignment restarts at the next word read.

## Test plan
- CHANNELS=2, FRAME_LEN=8, mode=0, ch_sel=1. Push L/R pairs (i, 100+i) for i=0..15, sink_ready=1.
  - Required: outputs 100..115; sop on 100 and 108; eop on 107 and 115; frame_cnt=2; fifo_rd_en never asserted on consecutive cycles.
- Mode 1, CHANNELS=2. Pairs (3, 4) → 3; (−3, −4) → −4; (0x7FFFFF, 0x7FFFFF) → 0x7FFFFF; (0x800000, 0x800000) → 0x800000.
- CHANNELS=4, mode 1. Group (1, 2, 3, 5) → 2. Toggle mode to 0 with ch_sel=2 at samp_idx=3.
  - Required: remainder of the frame stays averaged; the next frame outputs the channel-2 word.
- Backpressure: hold sink_ready=0 for 20 cycles with sink_valid=1.
  - Required: sink_real, sink_sop and sink_eop stable; fifo_rd_en=0 throughout; no sample lost or duplicated after release.
- FIFO drains mid-frame at samp_idx=5, then refills 50 cycles later.
  - Required: no spurious sink_valid; sample 6 continues the frame with no sop.
- Assert RESET for one edge at samp_idx=4.
  - Required: all outputs 0; next emitted sample has sop=1; frame_cnt=0.
